// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU data-memory responder.
// Firmware tests and the core bench use the same I/O offsets.
package cpu_pkg;

    localparam logic [7:0] IO_BASE_DEFAULT = 8'hF0;

    localparam logic [7:0] IO_GPIO_OUT = 8'd0;
    localparam logic [7:0] IO_GPIO_IN  = 8'd1;
    localparam logic [7:0] IO_TCNT     = 8'd2;
    localparam logic [7:0] IO_TPRE     = 8'd3;
    localparam logic [7:0] IO_TSTAT    = 8'd4;

    typedef enum logic [1:0] {
        TSEL_TCNT,
        TSEL_TPRE,
        TSEL_TSTAT,
        TSEL_NONE
    } timerSel_e;

    typedef struct packed {
        logic       en;
        timerSel_e  sel;
        logic [7:0] data;
    } timerWr_t;

    typedef struct packed {
        logic [7:0] tcnt;
        logic [7:0] tpre;
        logic       ovf;
    } timerRd_t;

endpackage

// File: rtl/io_timer.sv
// Prescaled 8-bit timer with a sticky overflow flag.
// TCNT advances once every TPRE+1 cycles; the prescale counter is 8 bits and wraps naturally.
module io_timer
    import cpu_pkg::*;
(
    input  logic     _iClk,
    input  logic     _iReset_n,
    input  timerWr_t timerWr,
    output timerRd_t timerRd
);

    logic [7:0] tcnt, tpre, pc;
    logic       ovf;
    logic       tick, tcntWr, tpreWr, ovfClr, wrap;

    assign tick   = (pc == tpre);
    assign tcntWr = timerWr.en && (timerWr.sel == TSEL_TCNT);
    assign tpreWr = timerWr.en && (timerWr.sel == TSEL_TPRE);
    assign ovfClr = timerWr.en && (timerWr.sel == TSEL_TSTAT) && timerWr.data[0];
    // A TCNT load pre-empts the increment, so it can never raise OVF.
    assign wrap   = tick && (tcnt == 8'hFF) && !tcntWr;

    always_ff @(posedge _iClk or negedge _iReset_n) begin
        if (!_iReset_n) begin
            tcnt <= '0;
            tpre <= '0;
            pc   <= '0;
            ovf  <= 1'b0;
        end else begin
            if (tcntWr) begin
                tcnt <= timerWr.data;
                pc   <= '0;
            end else if (tick) begin
                tcnt <= tcnt + 8'd1;
                pc   <= '0;
            end else begin
                pc   <= pc + 8'd1;
            end
            if (tpreWr)
                tpre <= timerWr.data;
            // Set beats a coincident clear.
            ovf <= wrap | (ovf & ~ovfClr);
        end
    end

    assign timerRd.tcnt = tcnt;
    assign timerRd.tpre = tpre;
    assign timerRd.ovf  = ovf;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the micro core: RAM below IO_BASE, GPIO and timer above it.
// Reads are combinational so the core can sample them one edge after driving the address.
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter logic [7:0] IO_BASE     = IO_BASE_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       _iClk,
    input  logic       _iReset_n,
    input  logic [7:0] _iDataMemAddr,
    input  logic [7:0] _iDataMemWData,
    input  logic       _iDataMemWrite,
    output logic [7:0] _oDataMemRData,
    input  logic [7:0] _iGpio,
    output logic [7:0] _oGpio,
    output logic       _oTimerOvf
);

    logic [7:0]                   ram [IO_BASE];
    logic [SYNC_STAGES-1:0][7:0]  syncQ;
    logic [7:0]                   gpioOut;
    logic [7:0]                   ioOff;
    logic                         isRam;
    timerWr_t                     timerWr;
    timerRd_t                     timerRd;

    assign isRam = (_iDataMemAddr < IO_BASE);
    assign ioOff = _iDataMemAddr - IO_BASE;

    // RAM has no reset; contents survive an I/O reset.
    always_ff @(posedge _iClk) begin
        if (_iDataMemWrite && isRam)
            ram[_iDataMemAddr] <= _iDataMemWData;
    end

    always_ff @(posedge _iClk or negedge _iReset_n) begin
        if (!_iReset_n) begin
            syncQ   <= '0;
            gpioOut <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], _iGpio};
            if (_iDataMemWrite && !isRam && (ioOff == IO_GPIO_OUT))
                gpioOut <= _iDataMemWData;
        end
    end

    always_comb begin
        timerWr.en   = 1'b0;
        timerWr.sel  = TSEL_NONE;
        timerWr.data = _iDataMemWData;
        if (_iDataMemWrite && !isRam) begin
            case (ioOff)
                IO_TCNT:  begin timerWr.en = 1'b1; timerWr.sel = TSEL_TCNT;  end
                IO_TPRE:  begin timerWr.en = 1'b1; timerWr.sel = TSEL_TPRE;  end
                IO_TSTAT: begin timerWr.en = 1'b1; timerWr.sel = TSEL_TSTAT; end
                default:  ;
            endcase
        end
    end

    io_timer uTimer (
        ._iClk     (_iClk),
        ._iReset_n (_iReset_n),
        .timerWr   (timerWr),
        .timerRd   (timerRd)
    );

    always_comb begin
        _oDataMemRData = 8'h00;
        if (isRam) begin
            _oDataMemRData = ram[_iDataMemAddr];
        end else begin
            case (ioOff)
                IO_GPIO_OUT: _oDataMemRData = gpioOut;
                IO_GPIO_IN:  _oDataMemRData = syncQ[SYNC_STAGES-1];
                IO_TCNT:     _oDataMemRData = timerRd.tcnt;
                IO_TPRE:     _oDataMemRData = timerRd.tpre;
                IO_TSTAT:    _oDataMemRData = {7'b0, timerRd.ovf};
                default:     _oDataMemRData = 8'h00;
            endcase
        end
    end

    assign _oGpio     = gpioOut;
    assign _oTimerOvf = timerRd.ovf;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table for RAM/GPIO, hand sequences for the timer and reset.
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = '0, wdata = '0, gpioIn = '0;
    logic       wr = 1'b0;
    logic [7:0] rdata, gpioOut;
    logic       ovf;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        ._iClk          (clk),
        ._iReset_n      (rst_n),
        ._iDataMemAddr  (addr),
        ._iDataMemWData (wdata),
        ._iDataMemWrite (wr),
        ._oDataMemRData (rdata),
        ._iGpio         (gpioIn),
        ._oGpio         (gpioOut),
        ._oTimerOvf     (ovf)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] gpioIn;
        logic       chkR;
        logic [7:0] expR;
        logic [7:0] expGpio;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic w, logic [7:0] a, logic [7:0] d, logic [7:0] g,
                                logic c, logic [7:0] er, logic [7:0] eg);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.gpioIn = g;
        v.chkR = c; v.expR = er; v.expGpio = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Called in the low phase; each peek advances 1ns, well before the next rising edge.
    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;

        vecs[0]  = mk(0, 8'hF0, 8'h00, 8'h00, 1, 8'h00, 8'h00);
        vecs[1]  = mk(1, 8'h10, 8'h5A, 8'h00, 0, 8'h00, 8'h00);
        vecs[2]  = mk(0, 8'h10, 8'h00, 8'h00, 1, 8'h5A, 8'h00);
        vecs[3]  = mk(1, 8'hEF, 8'h3C, 8'h00, 0, 8'h00, 8'h00);
        vecs[4]  = mk(0, 8'hEF, 8'h00, 8'h00, 1, 8'h3C, 8'h00);
        vecs[5]  = mk(0, 8'hF0, 8'h00, 8'h00, 1, 8'h00, 8'h00);
        vecs[6]  = mk(1, 8'hF0, 8'hC3, 8'h00, 1, 8'h00, 8'h00);
        vecs[7]  = mk(0, 8'hF1, 8'h00, 8'h96, 1, 8'h00, 8'hC3);
        vecs[8]  = mk(0, 8'hF1, 8'h00, 8'h96, 1, 8'h00, 8'hC3);
        vecs[9]  = mk(0, 8'hF1, 8'h00, 8'h96, 1, 8'h96, 8'hC3);
        vecs[10] = mk(1, 8'hF1, 8'hFF, 8'h96, 1, 8'h96, 8'hC3);
        vecs[11] = mk(0, 8'hF1, 8'h00, 8'h96, 1, 8'h96, 8'hC3);
        vecs[12] = mk(0, 8'hF5, 8'h00, 8'h96, 1, 8'h00, 8'hC3);
        vecs[13] = mk(0, 8'hFF, 8'h00, 8'h96, 1, 8'h00, 8'hC3);
        vecs[14] = mk(1, 8'hFA, 8'h12, 8'h96, 1, 8'h00, 8'hC3);
        vecs[15] = mk(0, 8'hFA, 8'h00, 8'h96, 1, 8'h00, 8'hC3);
        vecs[16] = mk(0, 8'hF0, 8'h00, 8'h96, 1, 8'hC3, 8'hC3);

        // Reset state
        tick(2);
        chk("rst_gpio", gpioOut, 8'h00);
        chk("rst_ovf", {7'b0, ovf}, 8'h00);
        peek(8'hF2, v); chk("rst_tcnt", v, 8'h00);
        peek(8'hF3, v); chk("rst_tpre", v, 8'h00);
        rst_n = 1'b1;

        // Table: inputs held for one cycle, outputs checked before that cycle's edge
        for (int i = 0; i < 17; i++) begin
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            wr = vecs[i].wr; gpioIn = vecs[i].gpioIn;
            #1;
            if (vecs[i].chkR) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].expR);
            chk($sformatf("vec%0d_gpio", i), gpioOut, vecs[i].expGpio);
            chk($sformatf("vec%0d_ovf", i), {7'b0, ovf}, 8'h00);
            @(posedge clk);
            @(negedge clk);
        end
        wr = 1'b0;

        // Prescale TPRE=3: one increment per 4 cycles
        writeReg(8'hF3, 8'h03);
        writeReg(8'hF2, 8'h00);
        tick(19);
        peek(8'hF2, v); chk("pre3_19cyc", v, 8'h04);
        tick(1);
        peek(8'hF2, v); chk("pre3_20cyc", v, 8'h05);

        // TPRE=0: every cycle
        writeReg(8'hF3, 8'h00);
        writeReg(8'hF2, 8'h10);
        peek(8'hF2, v); chk("pre0_load", v, 8'h10);
        tick(1);
        peek(8'hF2, v); chk("pre0_inc1", v, 8'h11);
        tick(1);
        peek(8'hF2, v); chk("pre0_inc2", v, 8'h12);

        // Overflow two cycles after loading 0xFE
        writeReg(8'hF2, 8'hFE);
        chk("ovf_pre", {7'b0, ovf}, 8'h00);
        tick(1);
        peek(8'hF2, v); chk("ovf_ff", v, 8'hFF);
        tick(1);
        peek(8'hF2, v); chk("ovf_wrap_tcnt", v, 8'h00);
        peek(8'hF4, v); chk("ovf_tstat", v, 8'h01);
        chk("ovf_pin", {7'b0, ovf}, 8'h01);
        writeReg(8'hF4, 8'h00);
        chk("ovf_write0_keeps", {7'b0, ovf}, 8'h01);
        writeReg(8'hF4, 8'h01);
        chk("ovf_clear", {7'b0, ovf}, 8'h00);

        // Clear coincident with wrap: set wins
        writeReg(8'hF2, 8'hFE);
        tick(1);
        writeReg(8'hF4, 8'h01);
        chk("coll_clr_wrap_ovf", {7'b0, ovf}, 8'h01);
        peek(8'hF2, v); chk("coll_clr_wrap_tcnt", v, 8'h00);

        // TCNT load coincident with would-be wrap
        writeReg(8'hF4, 8'h01);
        chk("coll_pre_ovf", {7'b0, ovf}, 8'h00);
        writeReg(8'hF2, 8'hFF);
        writeReg(8'hF2, 8'h40);
        peek(8'hF2, v); chk("coll_load_tcnt", v, 8'h40);
        chk("coll_load_ovf", {7'b0, ovf}, 8'h00);
        tick(1);
        peek(8'hF2, v); chk("coll_load_next", v, 8'h41);

        // Reset mid-run: I/O clears asynchronously, RAM survives
        writeReg(8'hF2, 8'hFE);
        tick(2);
        chk("mid_ovf_set", {7'b0, ovf}, 8'h01);
        writeReg(8'hF3, 8'h07);
        writeReg(8'hF0, 8'hAA);
        writeReg(8'h20, 8'h77);
        chk("mid_gpio_aa", gpioOut, 8'hAA);
        addr = 8'hF2;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gpio", gpioOut, 8'h00);
        chk("mid_rst_ovf", {7'b0, ovf}, 8'h00);
        chk("mid_rst_tcnt", rdata, 8'h00);
        tick(1);
        peek(8'hF3, v); chk("mid_rst_tpre", v, 8'h00);
        peek(8'hF2, v); chk("mid_rst_tcnt_held", v, 8'h00);
        rst_n = 1'b1;
        peek(8'h20, v); chk("mid_ram_kept", v, 8'h77);
        peek(8'hF5, v); chk("mid_unmapped", v, 8'h00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
